// File: rtl/axi_lite_mem_arbiter_if.sv
// One AXI-lite link (AR, R, AW, W, B). The arbiter faces the masters through the
// slave modport and faces the shared memory through the master modport.
interface axi_lite_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   araddr;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;
    logic [ADDR_W-1:0]   awaddr;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    modport master (
        output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );

    modport slave (
        input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/axi_lite_mem_arbiter.sv
// Round-robin arbiter giving the shared memory slave to the IFU (m0, read-only) or the LSU (m1)
// one whole transaction at a time. States: IDLE, RD0 (IFU read), RD1 (LSU read), WR1 (LSU write).
module axi_lite_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    axi_lite_mem_arbiter_if.slave  m0_if,
    axi_lite_mem_arbiter_if.slave  m1_if,
    axi_lite_mem_arbiter_if.master s_if
);
    typedef enum logic [1:0] {IDLE, RD0, RD1, WR1} state_e;

    state_e state_q, state_d;
    logic   last_q, last_d;
    logic   ar_done_q, ar_done_d;
    logic   aw_done_q, aw_done_d;
    logic   w_done_q, w_done_d;
    logic   req0, req1r, req1w;
    logic   ar_hs, aw_hs, w_hs;

    // The IFU never writes; its write-side inputs are intentionally ignored.
    logic   unused_m0;
    assign unused_m0 = ^{m0_if.awaddr, m0_if.awvalid, m0_if.wdata, m0_if.wstrb,
                         m0_if.wvalid, m0_if.bready};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            ar_done_q <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            ar_done_q <= ar_done_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        ar_done_d = ar_done_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        req0      = m0_if.arvalid;
        req1r     = m1_if.arvalid;
        req1w     = m1_if.awvalid | m1_if.wvalid;
        ar_hs     = 1'b0;
        aw_hs     = 1'b0;
        w_hs      = 1'b0;

        m0_if.arready = 1'b0;
        m0_if.rdata   = {DATA_W{1'b0}};
        m0_if.rresp   = 2'b00;
        m0_if.rvalid  = 1'b0;
        m0_if.awready = 1'b0;
        m0_if.wready  = 1'b0;
        m0_if.bresp   = 2'b00;
        m0_if.bvalid  = 1'b0;
        m1_if.arready = 1'b0;
        m1_if.rdata   = {DATA_W{1'b0}};
        m1_if.rresp   = 2'b00;
        m1_if.rvalid  = 1'b0;
        m1_if.awready = 1'b0;
        m1_if.wready  = 1'b0;
        m1_if.bresp   = 2'b00;
        m1_if.bvalid  = 1'b0;
        s_if.araddr   = {ADDR_W{1'b0}};
        s_if.arvalid  = 1'b0;
        s_if.rready   = 1'b0;
        s_if.awaddr   = {ADDR_W{1'b0}};
        s_if.awvalid  = 1'b0;
        s_if.wdata    = {DATA_W{1'b0}};
        s_if.wstrb    = '0;
        s_if.wvalid   = 1'b0;
        s_if.bready   = 1'b0;

        case (state_q)
            IDLE: begin
                // last_q names the most recent owner, so a tie goes to the other master
                if (req0 && (!(req1r || req1w) || last_q)) begin
                    state_d = RD0;
                    last_d  = 1'b0;
                end else if (req1r || req1w) begin
                    state_d = req1w ? WR1 : RD1;
                    last_d  = 1'b1;
                end
            end
            RD0: begin
                s_if.araddr   = m0_if.araddr;
                s_if.arvalid  = m0_if.arvalid & ~ar_done_q;
                m0_if.arready = s_if.arready & ~ar_done_q;
                s_if.rready   = m0_if.rready;
                m0_if.rvalid  = s_if.rvalid;
                m0_if.rdata   = s_if.rdata;
                m0_if.rresp   = s_if.rresp;
                ar_hs         = m0_if.arvalid & ~ar_done_q & s_if.arready;
                ar_done_d     = ar_done_q | ar_hs;
                if (s_if.rvalid && m0_if.rready) begin
                    state_d   = IDLE;
                    ar_done_d = 1'b0;
                end
            end
            RD1: begin
                s_if.araddr   = m1_if.araddr;
                s_if.arvalid  = m1_if.arvalid & ~ar_done_q;
                m1_if.arready = s_if.arready & ~ar_done_q;
                s_if.rready   = m1_if.rready;
                m1_if.rvalid  = s_if.rvalid;
                m1_if.rdata   = s_if.rdata;
                m1_if.rresp   = s_if.rresp;
                ar_hs         = m1_if.arvalid & ~ar_done_q & s_if.arready;
                ar_done_d     = ar_done_q | ar_hs;
                if (s_if.rvalid && m1_if.rready) begin
                    state_d   = IDLE;
                    ar_done_d = 1'b0;
                end
            end
            WR1: begin
                s_if.awaddr   = m1_if.awaddr;
                s_if.awvalid  = m1_if.awvalid & ~aw_done_q;
                m1_if.awready = s_if.awready & ~aw_done_q;
                s_if.wdata    = m1_if.wdata;
                s_if.wstrb    = m1_if.wstrb;
                s_if.wvalid   = m1_if.wvalid & ~w_done_q;
                m1_if.wready  = s_if.wready & ~w_done_q;
                s_if.bready   = m1_if.bready;
                m1_if.bvalid  = s_if.bvalid;
                m1_if.bresp   = s_if.bresp;
                aw_hs         = m1_if.awvalid & ~aw_done_q & s_if.awready;
                w_hs          = m1_if.wvalid & ~w_done_q & s_if.wready;
                aw_done_d     = aw_done_q | aw_hs;
                w_done_d      = w_done_q | w_hs;
                if (s_if.bvalid && m1_if.bready) begin
                    state_d   = IDLE;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_axi_lite_mem_arbiter.sv
// Randomized bench: bus-level masters and a memory slave around the arbiter, with a
// transaction-order reference model and pass-through checks on every completed transfer.
module tb_axi_lite_mem_arbiter;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 300;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axi_lite_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m0_if ();
    axi_lite_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m1_if ();
    axi_lite_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) s_if ();

    axi_lite_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .m0_if (m0_if),
        .m1_if (m1_if),
        .s_if  (s_if)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // ---------------- memory slave model ----------------
    int          stall_pct = 30;
    int          n_ar, n_r, n_aw, n_w, n_b;
    logic [31:0] sl_araddr, sl_awaddr, sl_wdata;
    logic [3:0]  sl_wstrb;
    logic        rd_pend, aw_got, w_got;
    int          rdly;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_if.arready <= 1'b0;  s_if.rvalid <= 1'b0;  s_if.rdata <= '0;  s_if.rresp <= '0;
            s_if.awready <= 1'b0;  s_if.wready <= 1'b0;  s_if.bvalid <= 1'b0; s_if.bresp <= '0;
            rd_pend <= 1'b0;  aw_got <= 1'b0;  w_got <= 1'b0;  rdly <= 0;
            n_ar <= 0;  n_r <= 0;  n_aw <= 0;  n_w <= 0;  n_b <= 0;
        end else begin
            s_if.arready <= ($urandom_range(0, 99) >= stall_pct);
            s_if.awready <= ($urandom_range(0, 99) >= stall_pct);
            s_if.wready  <= ($urandom_range(0, 99) >= stall_pct);
            if (s_if.arvalid && s_if.arready) begin
                n_ar <= n_ar + 1;  sl_araddr <= s_if.araddr;
                rd_pend <= 1'b1;   rdly <= $urandom_range(0, 3);
            end
            if (rd_pend && !s_if.rvalid) begin
                if (rdly == 0) begin
                    s_if.rvalid <= 1'b1;
                    s_if.rdata  <= $urandom;
                    s_if.rresp  <= ($urandom_range(0, 2) == 0) ? 2'd2 : 2'd0;
                    rd_pend     <= 1'b0;
                end else rdly <= rdly - 1;
            end
            if (s_if.rvalid && s_if.rready) begin
                s_if.rvalid <= 1'b0;  n_r <= n_r + 1;
            end
            if (s_if.awvalid && s_if.awready) begin
                n_aw <= n_aw + 1;  sl_awaddr <= s_if.awaddr;  aw_got <= 1'b1;
            end
            if (s_if.wvalid && s_if.wready) begin
                n_w <= n_w + 1;  sl_wdata <= s_if.wdata;  sl_wstrb <= s_if.wstrb;  w_got <= 1'b1;
            end
            if (aw_got && w_got) begin
                s_if.bvalid <= 1'b1;
                s_if.bresp  <= ($urandom_range(0, 2) == 0) ? 2'd2 : 2'd0;
                aw_got <= 1'b0;  w_got <= 1'b0;
            end
            if (s_if.bvalid && s_if.bready) begin
                s_if.bvalid <= 1'b0;  n_b <= n_b + 1;
            end
        end
    end

    // ---------------- bus invariants ----------------
    int v_excl = 0, v_m0w = 0, v_gap = 0;
    bit resp_prev = 0;
    always @(posedge clk) begin
        if (!rst_n) resp_prev = 0;
        else begin
            logic g0, g1r, g1w;
            g0  = m0_if.arready | m0_if.rvalid;
            g1r = m1_if.arready | m1_if.rvalid;
            g1w = m1_if.awready | m1_if.wready | m1_if.bvalid;
            if ((g0 && g1r) || (g0 && g1w) || (g1r && g1w)) v_excl++;
            if ((g1r || g1w) && (m0_if.rdata != 0 || m0_if.rresp != 0)) v_excl++;
            if ((s_if.arvalid || s_if.rready) && (s_if.awvalid || s_if.wvalid || s_if.bready)) v_excl++;
            if (m0_if.awready || m0_if.wready || m0_if.bvalid || m0_if.bresp != 0) v_m0w++;
            if (resp_prev && (s_if.arvalid || s_if.awvalid || s_if.wvalid)) v_gap++;
            resp_prev = (s_if.rvalid && s_if.rready) || (s_if.bvalid && s_if.bready);
        end
    end

    // ---------------- master side ----------------
    int done_q[$];
    int iss_rd = 0, iss_wr = 0;
    bit exp_last = 1'b1;

    function automatic logic [15:0] outs();
        return {m0_if.arready, m0_if.rvalid, m1_if.arready, m1_if.rvalid, m1_if.awready,
                m1_if.wready, m1_if.bvalid, s_if.arvalid, s_if.rready, s_if.awvalid,
                s_if.wvalid, s_if.bready, m0_if.awready, m0_if.wready, m0_if.bvalid, 1'b0};
    endfunction

    function automatic logic arrdy(input int who);
        return (who == 0) ? m0_if.arready : m1_if.arready;
    endfunction
    function automatic logic rvld(input int who);
        return (who == 0) ? m0_if.rvalid : m1_if.rvalid;
    endfunction
    function automatic logic [31:0] rdat(input int who);
        return (who == 0) ? m0_if.rdata : m1_if.rdata;
    endfunction
    function automatic logic [1:0] rrsp(input int who);
        return (who == 0) ? m0_if.rresp : m1_if.rresp;
    endfunction

    task automatic drv_ar(input int who, input logic v, input logic [31:0] a);
        if (who == 0) begin m0_if.arvalid = v; m0_if.araddr = a; end
        else          begin m1_if.arvalid = v; m1_if.araddr = a; end
    endtask
    task automatic drv_rr(input int who, input logic v);
        if (who == 0) m0_if.rready = v;
        else          m1_if.rready = v;
    endtask

    task automatic rd_task(input int who, input logic [31:0] a);
        int n = 0;
        bit ok = 0, have_held = 0;
        logic rr;
        logic [31:0] held = '0;
        drv_ar(who, 1'b1, a);
        while (n < TMO) begin
            #1;
            if (arrdy(who)) begin ok = 1; break; end
            @(negedge clk);  n++;
        end
        chk($sformatf("m%0d_ar_hs", who), ok, 1);
        if (ok) begin @(posedge clk); @(negedge clk); end
        drv_ar(who, 1'b0, '0);
        if (!ok) return;
        n = 0;  ok = 0;
        while (n < TMO) begin
            rr = ($urandom_range(0, 2) != 0);
            drv_rr(who, rr);
            #1;
            if (rvld(who) && rr) begin ok = 1; break; end
            if (rvld(who) && !have_held) begin held = rdat(who); have_held = 1; end
            @(negedge clk);  n++;
        end
        chk($sformatf("m%0d_r_hs", who), ok, 1);
        if (ok) begin
            chk($sformatf("m%0d_rdata", who), rdat(who), s_if.rdata);
            chk($sformatf("m%0d_rresp", who), rrsp(who), s_if.rresp);
            chk($sformatf("m%0d_araddr", who), sl_araddr, a);
            if (have_held) chk($sformatf("m%0d_r_stable", who), rdat(who), held);
            done_q.push_back(who == 0 ? 0 : 2);
            iss_rd++;
            @(posedge clk); @(negedge clk);
        end
        drv_rr(who, 1'b0);
    endtask

    task automatic wr_task(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st,
                           input int skew);
        int n = 0;
        bit ok = 0, br;
        fork
            begin
                int na = 0;
                bit oka = 0;
                if (skew < 0) repeat (-skew) @(negedge clk);
                m1_if.awaddr = a;  m1_if.awvalid = 1'b1;
                while (na < TMO) begin
                    #1;
                    if (m1_if.awready) begin oka = 1; break; end
                    @(negedge clk);  na++;
                end
                chk("aw_hs", oka, 1);
                if (oka) begin @(posedge clk); @(negedge clk); end
                m1_if.awvalid = 1'b0;
            end
            begin
                int nw = 0;
                bit okw = 0;
                if (skew > 0) repeat (skew) @(negedge clk);
                m1_if.wdata = d;  m1_if.wstrb = st;  m1_if.wvalid = 1'b1;
                while (nw < TMO) begin
                    #1;
                    if (m1_if.wready) begin okw = 1; break; end
                    @(negedge clk);  nw++;
                end
                chk("w_hs", okw, 1);
                if (okw) begin @(posedge clk); @(negedge clk); end
                m1_if.wvalid = 1'b0;
            end
        join
        while (n < TMO) begin
            br = ($urandom_range(0, 2) != 0);
            m1_if.bready = br;
            #1;
            if (m1_if.bvalid && br) begin ok = 1; break; end
            @(negedge clk);  n++;
        end
        chk("b_hs", ok, 1);
        if (ok) begin
            chk("bresp", m1_if.bresp, s_if.bresp);
            chk("awaddr", sl_awaddr, a);
            chk("wdata", sl_wdata, d);
            chk("wstrb", sl_wstrb, st);
            done_q.push_back(1);
            iss_wr++;
            @(posedge clk); @(negedge clk);
        end
        m1_if.bready = 1'b0;
    endtask

    // op1: 0 none, 1 read, 2 write, 3 write and read together
    task automatic run_round(input bit do0, input int op1, input logic [31:0] a0);
        int exp_q[$];
        bit p0 = do0, p1w = (op1 >= 2), p1r = (op1 == 1 || op1 == 3);
        while (p0 || p1w || p1r) begin
            if (p0 && (!(p1w || p1r) || exp_last)) begin
                exp_q.push_back(0);  p0 = 0;  exp_last = 0;
            end else begin
                if (p1w) begin exp_q.push_back(1); p1w = 0; end
                else     begin exp_q.push_back(2); p1r = 0; end
                exp_last = 1;
            end
        end
        done_q.delete();
        @(negedge clk);
        fork
            begin if (do0) rd_task(0, a0); end
            begin if (op1 == 1 || op1 == 3) rd_task(1, $urandom); end
            begin
                if (op1 >= 2)
                    wr_task($urandom, $urandom, 4'($urandom_range(1, 15)),
                            int'($urandom_range(0, 4)) - 2);
            end
            begin #1; chk("no_early_valid", {s_if.arvalid, s_if.awvalid, s_if.wvalid}, 0); end
        join
        chk("n_done", done_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < done_q.size(); k++)
            chk($sformatf("order%0d", k), done_q[k], exp_q[k]);
    endtask

    initial begin
        bit seen;
        m0_if.arvalid = 0; m0_if.araddr = '0; m0_if.rready = 0; m0_if.awvalid = 0;
        m0_if.awaddr = '0; m0_if.wvalid = 0; m0_if.wdata = '0; m0_if.wstrb = '0; m0_if.bready = 0;
        m1_if.arvalid = 0; m1_if.araddr = '0; m1_if.rready = 0; m1_if.awvalid = 0;
        m1_if.awaddr = '0; m1_if.wvalid = 0; m1_if.wdata = '0; m1_if.wstrb = '0; m1_if.bready = 0;

        repeat (3) @(negedge clk);
        m0_if.arvalid = 1; m1_if.awvalid = 1; m1_if.wvalid = 1; m0_if.rready = 1; m1_if.bready = 1;
        repeat (2) @(negedge clk);
        #1 chk("reset_outs", outs(), 0);
        m0_if.arvalid = 0; m1_if.awvalid = 0; m1_if.wvalid = 0; m0_if.rready = 0; m1_if.bready = 0;
        @(negedge clk) rst_n = 1;

        run_round(1, 0, 32'h8000_0000);
        run_round(1, 1, 32'h8000_0004);
        run_round(1, 1, 32'h8000_0008);
        run_round(0, 2, 32'h0);
        run_round(1, 3, 32'h8000_000c);
        stall_pct = 80;
        run_round(1, 2, 32'h8000_0010);
        run_round(1, 1, 32'h8000_0014);
        for (int i = 0; i < 40; i++) begin
            bit d0 = bit'($urandom_range(0, 1));
            int o1 = int'($urandom_range(0, 3));
            stall_pct = int'($urandom_range(0, 70));
            if (!d0 && o1 == 0) d0 = 1;
            run_round(d0, o1, $urandom);
        end

        chk("n_ar", n_ar, iss_rd);
        chk("n_r", n_r, iss_rd);
        chk("n_aw", n_aw, iss_wr);
        chk("n_w", n_w, iss_wr);
        chk("n_b", n_b, iss_wr);

        // abandon an LSU write in flight
        stall_pct = 90;
        @(negedge clk);
        m1_if.awaddr = 32'h8000_1000; m1_if.awvalid = 1;
        m1_if.wdata = 32'hdead_beef; m1_if.wstrb = 4'hf; m1_if.wvalid = 1; m1_if.bready = 1;
        seen = 0;
        for (int n = 0; n < TMO && !seen; n++) begin
            #1 seen = s_if.awvalid | s_if.wvalid;
            if (!seen) @(negedge clk);
        end
        chk("wr1_granted", seen, 1);
        #2 rst_n = 0;
        #1 chk("reset_mid_op", outs(), 0);
        m1_if.awvalid = 0; m1_if.wvalid = 0; m1_if.bready = 0;
        iss_rd = 0; iss_wr = 0; exp_last = 1;
        @(negedge clk);
        chk("reset_hold", outs(), 0);
        @(negedge clk) rst_n = 1;
        stall_pct = 30;
        run_round(1, 1, 32'h8000_0020);
        run_round(1, 2, 32'h8000_0024);

        chk("n_ar_post", n_ar, iss_rd);
        chk("n_aw_post", n_aw, iss_wr);
        chk("n_b_post", n_b, iss_wr);
        chk("excl_violations", v_excl, 0);
        chk("m0_write_violations", v_m0w, 0);
        chk("idle_gap_violations", v_gap, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
